// File: rtl/aibcr3_tx_pkg.sv
// Shared types for the AIB transmit lane: mode and sequencer state encodings
// plus the itxen mode-code decoder.
package aibcr3_tx_pkg;

  typedef enum logic [2:0] {
    ASYNC,
    DDR,
    SDR,
    CLK,
    DIS
  } tx_mode_e;

  typedef enum logic [1:0] {
    DISABLED,
    SETTLE,
    ACTIVE,
    QUIESCE
  } tx_state_e;

  // Unlisted codes fall back to DIS so the pad is never driven by garbage.
  function automatic tx_mode_e decode_txen(input logic [2:0] txen);
    case (txen)
      3'b000:  return ASYNC;
      3'b001:  return DDR;
      3'b011:  return CLK;
      3'b100:  return SDR;
      default: return DIS;
    endcase
  endfunction

endpackage

// File: rtl/aibcr3_tx_clkgate.sv
// Latch-based clock gate; the latch is transparent while clk is low, so en can
// only change the gated output between full high pulses.
module aibcr3_tx_clkgate (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_l;

  always_latch begin
    if (!rst_n) begin
      en_l <= 1'b0;
    end else if (!clk) begin
      en_l <= en;
    end
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/aibcr3_txdig_ser.sv
// AIB lane transmit serializer: mode sequencer (settle/quiesce windows) and the
// DDR / SDR / forwarded-clock / async pad data mux.
module aibcr3_txdig_ser
  import aibcr3_tx_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       iclkin_dist,
  input  logic       irstb,
  input  logic [2:0] itxen,
  input  logic       idat0,
  input  logic       idat1,
  input  logic       iasync_dat,
  output logic       odat,
  output logic       oe,
  output logic       tx_disable,
  output logic       tx_ready
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  tx_state_e        state_q, state_d;
  tx_mode_e         mode_q, mode_d;
  tx_mode_e         nmode;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d0_q, d1_q;
  logic             gate_en;
  logic             gclk;

  assign nmode = decode_txen(itxen);

  // Registered control and data capture
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      state_q <= DISABLED;
      mode_q  <= DIS;
      cnt_q   <= '0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      d0_q    <= idat0;
      d1_q    <= idat1;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      DISABLED: begin
        if (nmode != DIS) begin
          state_d = SETTLE;
          mode_d  = nmode;
          cnt_d   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (nmode == DIS) begin
          state_d = DISABLED;
        end else if (nmode != mode_q) begin
          mode_d = nmode;
          cnt_d  = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (nmode == DIS) begin
          state_d = DISABLED;
        end else if (nmode != mode_q) begin
          state_d = QUIESCE;
        end
      end
      QUIESCE: begin
        if (nmode == DIS) begin
          state_d = DISABLED;
        end else begin
          state_d = SETTLE;
          mode_d  = nmode;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // Requiring ACTIVE now and next keeps the entry and exit edges from emitting
  // a pulse that would be clipped by the state change.
  assign gate_en = (state_q == ACTIVE) && (state_d == ACTIVE) && (mode_q == CLK);

  aibcr3_tx_clkgate u_clkgate (
    .clk   (iclkin_dist),
    .rst_n (irstb),
    .en    (gate_en),
    .gclk  (gclk)
  );

  // Pad mux: both DDR sources change only at posedge, so the phase mux is clean
  always_comb begin
    odat = 1'b0;
    if (state_q == ACTIVE) begin
      case (mode_q)
        DDR:     odat = iclkin_dist ? d0_q : d1_q;
        SDR:     odat = d0_q;
        CLK:     odat = gclk;
        ASYNC:   odat = iasync_dat;
        default: odat = 1'b0;
      endcase
    end
  end

  assign oe         = (state_q != DISABLED);
  assign tx_disable = (state_q == DISABLED);
  assign tx_ready   = (state_q == ACTIVE);

endmodule

// File: tb/tb_aibcr3_txdig_ser.sv
// Randomized scoreboard bench for aibcr3_txdig_ser with a timestamp-based
// reference model of the settle/quiesce sequencing.
module tb_aibcr3_txdig_ser;

  localparam int S = 4;
  localparam int M_ASYNC = 0, M_DDR = 1, M_SDR = 2, M_CLK = 3, M_DIS = 4;

  logic       clk = 1'b0;
  logic       irstb = 1'b0;
  logic [2:0] itxen = 3'b010;
  logic       idat0 = 1'b0, idat1 = 1'b0, iasync_dat = 1'b0;
  logic       odat, oe, tx_disable, tx_ready;

  aibcr3_txdig_ser #(.SETTLE_CYCLES(S)) dut (
    .iclkin_dist (clk),
    .irstb       (irstb),
    .itxen       (itxen),
    .idat0       (idat0),
    .idat1       (idat1),
    .iasync_dat  (iasync_dat),
    .odat        (odat),
    .oe          (oe),
    .tx_disable  (tx_disable),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  // Expected {odat, oe, tx_disable, tx_ready} for the high and low phase after an edge
  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: timestamps instead of a countdown
  int edge_n   = 0;
  bit m_en     = 0;
  bit m_act    = 0;
  bit m_act_pv = 0;
  bit m_quiet  = 0;
  int m_target = M_DIS;
  int m_ready  = 0;

  function automatic int mode_of(input logic [2:0] c);
    case (c)
      3'b000:  return M_ASYNC;
      3'b001:  return M_DDR;
      3'b011:  return M_CLK;
      3'b100:  return M_SDR;
      default: return M_DIS;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_act = 0; m_quiet = 0; m_target = M_DIS;
  endtask

  // A mode is usable once it has been requested unchanged for S+1 edges; a
  // change while active first costs one dead edge.
  task automatic model_edge(input logic [2:0] code, input bit rstb);
    int m;
    m = mode_of(code);
    m_act_pv = m_act;
    if (!rstb || m == M_DIS) begin
      model_reset();
    end else if (!m_en) begin
      m_en = 1; m_target = m; m_ready = edge_n + S; m_act = 0;
    end else if (m_act) begin
      if (m != m_target) begin
        m_act = 0; m_quiet = 1;
      end
    end else if (m_quiet) begin
      m_quiet = 0; m_target = m; m_ready = edge_n + S;
    end else if (m != m_target) begin
      m_target = m; m_ready = edge_n + S;
    end else if (edge_n >= m_ready) begin
      m_act = 1;
    end
    edge_n++;
  endtask

  function automatic logic [3:0] expect_out(input bit hi, input logic d0, d1, a);
    logic o;
    o = 1'b0;
    if (m_act) begin
      case (m_target)
        M_DDR:   o = hi ? d0 : d1;
        M_SDR:   o = d0;
        M_CLK:   o = hi & m_act_pv;
        M_ASYNC: o = a;
        default: o = 1'b0;
      endcase
    end
    return {o, m_en, ~m_en, m_act};
  endfunction

  task automatic chk(input string name, input int cyc, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, got, exp);
    end
  endtask

  task automatic chk4(input string ph, input int cyc, input logic [3:0] e);
    chk({ph, "_odat"},       cyc, odat,       e[3]);
    chk({ph, "_oe"},         cyc, oe,         e[2]);
    chk({ph, "_tx_disable"}, cyc, tx_disable, e[1]);
    chk({ph, "_tx_ready"},   cyc, tx_ready,   e[0]);
  endtask

  // Monitor: every edge presents a new pad value; compare both phases
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk4("hi", e.cyc, e.hi);
        @(negedge clk);
        #1;
        chk4("lo", e.cyc, e.lo);
      end
    end
  end

  // One cycle of stimulus, entered and left at negedge+3
  task automatic cycle(input logic [2:0] code, input logic d0, d1, a,
                       input bit rstb, input bit rst_mid);
    exp_t e;
    irstb = rstb;
    itxen = code;
    idat0 = d0;
    idat1 = d1;
    model_edge(code, rstb);
    e.cyc = edge_n - 1;
    e.hi  = expect_out(1'b1, d0, d1, a);
    e.lo  = rst_mid ? 4'b0010 : expect_out(1'b0, d0, d1, a);
    sb.push_back(e);
    if (rst_mid) model_reset();
    @(posedge clk);
    #1 iasync_dat = a;
    if (rst_mid) begin
      #2 irstb = 1'b0;
      #1;
      chk("rst_async_odat", e.cyc, odat, 1'b0);
      chk("rst_async_oe",   e.cyc, oe,   1'b0);
    end
    @(negedge clk);
    #3;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  logic [2:0] codes [8] = '{3'b001, 3'b100, 3'b011, 3'b000, 3'b001, 3'b010, 3'b111, 3'b101};

  initial begin
    int len;
    logic [2:0] c;
    @(negedge clk);
    #3;
    // Reset held with activity on every input
    for (int i = 0; i < 3; i++) cycle(3'b001, rb(), rb(), rb(), 1'b0, 1'b0);
    // DDR bring-up and directed phase pattern
    for (int i = 0; i < S; i++) cycle(3'b001, rb(), rb(), rb(), 1'b1, 1'b0);
    cycle(3'b001, 1'b1, 1'b0, rb(), 1'b1, 1'b0);
    cycle(3'b001, 1'b0, 1'b1, rb(), 1'b1, 1'b0);
    cycle(3'b001, 1'b1, 1'b1, rb(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(3'b001, rb(), rb(), rb(), 1'b1, 1'b0);
    // SDR, then DDR -> CLK change while active
    for (int i = 0; i < 12; i++) cycle(3'b100, rb(), rb(), rb(), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  cycle(3'b001, rb(), rb(), rb(), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(3'b011, rb(), rb(), rb(), 1'b1, 1'b0);
    // Illegal code disables; code flipping every cycle never settles
    cycle(3'b111, rb(), rb(), rb(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle((i % 2) ? 3'b100 : 3'b001, rb(), rb(), rb(), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)  cycle(3'b010, rb(), rb(), rb(), 1'b1, 1'b0);
    // Async mode, asynchronous reset mid-ACTIVE, then async mode again
    for (int i = 0; i < 7; i++)  cycle(3'b000, rb(), rb(), rb(), 1'b1, 1'b0);
    cycle(3'b000, rb(), rb(), rb(), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++)  cycle(3'b000, rb(), rb(), rb(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(3'b000, rb(), rb(), rb(), 1'b1, 1'b0);
    // Random code runs of random length, occasional mid-cycle reset
    for (int r = 0; r < 60; r++) begin
      c   = codes[$urandom_range(0, 7)];
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 59) == 0) begin
          cycle(c, rb(), rb(), rb(), 1'b1, 1'b1);
          cycle(c, rb(), rb(), rb(), 1'b0, 1'b0);
        end else begin
          cycle(c, rb(), rb(), rb(), 1'b1, 1'b0);
        end
      end
    end
    for (int i = 0; i < 6 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
